// File: rtl/reg_scoreboard.sv
// reg_scoreboard: issue-stage RAW scoreboard for the LC-3b register file.
// Tracks in-flight writes per register and stalls issue on hazards.
//
// Ports:
//   clk, reset            clock; synchronous active-low reset
//   issue_valid           decode presents an instruction
//   issue_ready           instruction may issue this cycle (comb)
//   issue_src_a/_used     source A index / source A is read
//   issue_src_b/_used     source B index / source B is read
//   issue_dest/_used      destination index / dest is written
//   wb_valid, wb_dest     writeback loads the regfile this cycle
//   flush                 pipeline squash, clears all tracking
//   busy_mask             per-register "write in flight" (registered)
//   stall_count           saturating count of stalled issue cycles
//   underflow_err         sticky: writeback with no write in flight
//
// Build option: SCOREBOARD_WB_BYPASS_EN lets a source whose last
// pending write retires this cycle issue in the writeback cycle,
// because the regfile then writes on the negative edge.

module reg_scoreboard #(
  parameter  int NUM_REGS = 8,
  parameter  int CNT_W    = 2,
  parameter  int STALL_W  = 16,
  localparam int IDX_W    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                issue_valid,
  output logic                issue_ready,
  input  logic [IDX_W-1:0]    issue_src_a,
  input  logic                issue_src_a_used,
  input  logic [IDX_W-1:0]    issue_src_b,
  input  logic                issue_src_b_used,
  input  logic [IDX_W-1:0]    issue_dest,
  input  logic                issue_dest_used,
  input  logic                wb_valid,
  input  logic [IDX_W-1:0]    wb_dest,
  input  logic                flush,
  output logic [NUM_REGS-1:0] busy_mask,
  output logic [STALL_W-1:0]  stall_count,
  output logic                underflow_err
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0]    r_cnt     [NUM_REGS];
  logic [CNT_W-1:0]    w_cnt_nxt [NUM_REGS];
  logic [NUM_REGS-1:0] r_busy;
  logic [NUM_REGS-1:0] w_busy_nxt;
  logic [NUM_REGS-1:0] w_inc;
  logic [NUM_REGS-1:0] w_dec;
  logic [STALL_W-1:0]  r_stall;
  logic                r_uf;

  logic [CNT_W-1:0]    w_cnt_a;
  logic [CNT_W-1:0]    w_cnt_b;
  logic [CNT_W-1:0]    w_cnt_d;
  logic [CNT_W-1:0]    w_cnt_wb;
  logic                w_byp_a;
  logic                w_byp_b;
  logic                w_haz_a;
  logic                w_haz_b;
  logic                w_full_d;
  logic                w_ready;
  logic                w_fire;
  logic                w_uf_set;
  logic                w_stall;

  assign w_cnt_a  = r_cnt[issue_src_a];
  assign w_cnt_b  = r_cnt[issue_src_b];
  assign w_cnt_d  = r_cnt[issue_dest];
  assign w_cnt_wb = r_cnt[wb_dest];

`ifdef SCOREBOARD_WB_BYPASS_EN
  // Last outstanding write lands this cycle; data is readable
  // after the regfile's negedge write.
  assign w_byp_a = wb_valid
                && (wb_dest == issue_src_a)
                && (w_cnt_a == CNT_ONE);
  assign w_byp_b = wb_valid
                && (wb_dest == issue_src_b)
                && (w_cnt_b == CNT_ONE);
`else
  assign w_byp_a = 1'b0;
  assign w_byp_b = 1'b0;
`endif

  assign w_haz_a = issue_src_a_used
                && (w_cnt_a != '0)
                && !w_byp_a;
  assign w_haz_b = issue_src_b_used
                && (w_cnt_b != '0)
                && !w_byp_b;

  // A saturated counter cannot record another write.
  assign w_full_d = issue_dest_used
                 && (w_cnt_d == CNT_MAX);

  assign w_ready = reset
                && !flush
                && !w_haz_a
                && !w_haz_b
                && !w_full_d;

  assign w_fire  = issue_valid && w_ready;
  assign w_stall = issue_valid && !w_ready;

  // Flush discards any same-cycle writeback as well.
  assign w_uf_set = reset
                 && !flush
                 && wb_valid
                 && (w_cnt_wb == '0);

  always_comb begin
    w_inc      = '0;
    w_dec      = '0;
    w_busy_nxt = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      w_cnt_nxt[i] = r_cnt[i];
      w_inc[i] = w_fire
              && issue_dest_used
              && (issue_dest == IDX_W'(i));
      w_dec[i] = wb_valid
              && (wb_dest == IDX_W'(i));
      if (flush) begin
        w_cnt_nxt[i] = '0;
      end else if (w_inc[i] && !w_dec[i]) begin
        w_cnt_nxt[i] = r_cnt[i] + CNT_ONE;
      end else if (!w_inc[i] && w_dec[i]) begin
        if (r_cnt[i] != '0) begin
          w_cnt_nxt[i] = r_cnt[i] - CNT_ONE;
        end
      end else if (w_inc[i] && w_dec[i]) begin
        // A stray writeback against an idle register must not
        // swallow the write just issued.
        if (r_cnt[i] == '0) begin
          w_cnt_nxt[i] = CNT_ONE;
        end
      end
      w_busy_nxt[i] = (w_cnt_nxt[i] != '0);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_cnt[i] <= '0;
      end
      r_busy <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_cnt[i] <= w_cnt_nxt[i];
      end
      r_busy <= w_busy_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_stall <= '0;
    end else if (w_stall && (r_stall != '1)) begin
      r_stall <= r_stall + STALL_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_uf <= 1'b0;
    end else if (w_uf_set) begin
      r_uf <= 1'b1;
    end
  end

  assign issue_ready   = w_ready;
  assign busy_mask     = r_busy;
  assign stall_count   = r_stall;
  assign underflow_err = r_uf;

endmodule

// File: tb/tb_reg_scoreboard.sv
// tb_reg_scoreboard: vector table plus expected-result queue
// for reg_scoreboard.

module tb_reg_scoreboard;

`ifdef SCOREBOARD_WB_BYPASS_EN
  localparam int BP = 1;
`else
  localparam int BP = 0;
`endif
  localparam int S = 3 - BP;

  logic        clk = 1'b0;
  logic        reset;
  logic        issue_valid;
  logic        issue_ready;
  logic [2:0]  issue_src_a;
  logic        issue_src_a_used;
  logic [2:0]  issue_src_b;
  logic        issue_src_b_used;
  logic [2:0]  issue_dest;
  logic        issue_dest_used;
  logic        wb_valid;
  logic [2:0]  wb_dest;
  logic        flush;
  logic [7:0]  busy_mask;
  logic [15:0] stall_count;
  logic        underflow_err;

  always #5 clk = ~clk;

  reg_scoreboard dut (
    .clk              (clk),
    .reset            (reset),
    .issue_valid      (issue_valid),
    .issue_ready      (issue_ready),
    .issue_src_a      (issue_src_a),
    .issue_src_a_used (issue_src_a_used),
    .issue_src_b      (issue_src_b),
    .issue_src_b_used (issue_src_b_used),
    .issue_dest       (issue_dest),
    .issue_dest_used  (issue_dest_used),
    .wb_valid         (wb_valid),
    .wb_dest          (wb_dest),
    .flush            (flush),
    .busy_mask        (busy_mask),
    .stall_count      (stall_count),
    .underflow_err    (underflow_err)
  );

  typedef struct {
    logic        iv;
    logic [2:0]  sa;
    logic        sau;
    logic [2:0]  sb;
    logic        sbu;
    logic [2:0]  d;
    logic        du;
    logic        wv;
    logic [2:0]  wd;
    logic        fl;
    logic        rdy;
    logic [7:0]  busy;
    logic [15:0] stall;
    logic        uf;
  } vec_t;

  typedef struct {
    logic [7:0]  busy;
    logic [15:0] stall;
    logic        uf;
  } exp_t;

  vec_t tv[$];
  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   idx      = 0;

  function automatic vec_t v(
    input logic iv, input logic [2:0] sa, input logic sau,
    input logic [2:0] sb, input logic sbu,
    input logic [2:0] d, input logic du,
    input logic wv, input logic [2:0] wd, input logic fl,
    input logic rdy, input logic [7:0] busy,
    input int stall, input logic uf);
    vec_t t;
    t.iv = iv; t.sa = sa; t.sau = sau;
    t.sb = sb; t.sbu = sbu; t.d = d; t.du = du;
    t.wv = wv; t.wd = wd; t.fl = fl;
    t.rdy = rdy; t.busy = busy;
    t.stall = 16'(stall); t.uf = uf;
    return t;
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s step=%0d actual=%h required=%h",
               nm, idx, act, exp);
    end
  endtask

  task automatic drive(input vec_t t);
    issue_valid      = t.iv;
    issue_src_a      = t.sa;
    issue_src_a_used = t.sau;
    issue_src_b      = t.sb;
    issue_src_b_used = t.sbu;
    issue_dest       = t.d;
    issue_dest_used  = t.du;
    wb_valid         = t.wv;
    wb_dest          = t.wd;
    flush            = t.fl;
  endtask

  task automatic apply(input vec_t t);
    exp_t e;
    drive(t);
    #1;
    chk("issue_ready", 32'(issue_ready), 32'(t.rdy));
    e.busy  = t.busy;
    e.stall = t.stall;
    e.uf    = t.uf;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL queue_empty step=%0d actual=0 required=1",
               idx);
    end else begin
      e = sb_q.pop_front();
      chk("busy_mask", 32'(busy_mask), 32'(e.busy));
      chk("stall_count", 32'(stall_count), 32'(e.stall));
      chk("underflow_err", 32'(underflow_err), 32'(e.uf));
    end
    idx++;
  endtask

  initial begin
    // RAW on R3, with or without writeback bypass
    tv.push_back(v(1,0,0,0,0,3,1,0,0,0, 1,8'h08,0,0));
    tv.push_back(v(1,3,1,0,0,0,0,0,0,0, 0,8'h08,1,0));
    tv.push_back(v(1,3,1,0,0,0,0,0,0,0, 0,8'h08,2,0));
    tv.push_back(v(1,3,1,0,0,0,0,1,3,0, BP[0],8'h00,S,0));
    tv.push_back(v(1,3,1,0,0,0,0,0,0,0, 1,8'h00,S,0));
    // R5 counter saturation and recovery
    tv.push_back(v(1,0,0,0,0,5,1,0,0,0, 1,8'h20,S,0));
    tv.push_back(v(1,0,0,0,0,5,1,0,0,0, 1,8'h20,S,0));
    tv.push_back(v(1,0,0,0,0,5,1,0,0,0, 1,8'h20,S,0));
    tv.push_back(v(1,0,0,0,0,5,1,0,0,0, 0,8'h20,S+1,0));
    tv.push_back(v(1,0,0,0,0,5,1,1,5,0, 0,8'h20,S+2,0));
    tv.push_back(v(1,0,0,0,0,5,1,0,0,0, 1,8'h20,S+2,0));
    tv.push_back(v(1,0,0,0,0,5,1,0,0,0, 0,8'h20,S+3,0));
    tv.push_back(v(0,0,0,0,0,0,0,1,5,0, 1,8'h20,S+3,0));
    tv.push_back(v(0,0,0,0,0,0,0,1,5,0, 1,8'h20,S+3,0));
    tv.push_back(v(0,0,0,0,0,0,0,1,5,0, 1,8'h00,S+3,0));
    // same-cycle fire and writeback on R1
    tv.push_back(v(1,0,0,0,0,1,1,0,0,0, 1,8'h02,S+3,0));
    tv.push_back(v(1,0,0,0,0,1,1,1,1,0, 1,8'h02,S+3,0));
    tv.push_back(v(0,0,0,0,0,0,0,1,1,0, 1,8'h00,S+3,0));
    // flush with pending R0/R2/R7
    tv.push_back(v(1,0,0,0,0,0,1,0,0,0, 1,8'h01,S+3,0));
    tv.push_back(v(1,0,0,0,0,2,1,0,0,0, 1,8'h05,S+3,0));
    tv.push_back(v(1,0,0,0,0,7,1,0,0,0, 1,8'h85,S+3,0));
    tv.push_back(v(1,0,0,0,0,4,1,1,0,1, 0,8'h00,S+4,0));
    tv.push_back(v(1,0,1,7,1,0,0,0,0,0, 1,8'h00,S+4,0));
    // underflow on idle R4, sticky
    tv.push_back(v(0,0,0,0,0,0,0,1,4,0, 1,8'h00,S+4,1));
    tv.push_back(v(0,0,0,0,0,0,0,0,0,0, 1,8'h00,S+4,1));
    // src_b hazard; unused source is ignored
    tv.push_back(v(1,0,0,0,0,2,1,0,0,0, 1,8'h04,S+4,1));
    tv.push_back(v(1,0,0,2,1,0,0,0,0,0, 0,8'h04,S+5,1));
    tv.push_back(v(1,2,0,0,0,0,0,0,0,0, 1,8'h04,S+5,1));
    tv.push_back(v(0,0,0,0,0,0,0,1,2,0, 1,8'h00,S+5,1));
    tv.push_back(v(1,0,0,0,0,6,1,0,0,0, 1,8'h40,S+5,1));

    // reset held two cycles with an instruction presented
    reset = 1'b0;
    drive(v(1,0,0,0,0,2,1,0,0,0, 0,0,0,0));
    #1;
    chk("rst_ready0", 32'(issue_ready), 32'd0);
    @(posedge clk);
    #1;
    chk("rst_ready1", 32'(issue_ready), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    chk("rst_busy", 32'(busy_mask), 32'h00);
    chk("rst_stall", 32'(stall_count), 32'd0);
    chk("rst_uf", 32'(underflow_err), 32'd0);

    for (int i = 0; i < tv.size(); i++) begin
      apply(tv[i]);
    end

    // stall against pending R6 until the counter saturates
    drive(v(1,6,1,0,0,0,0,0,0,0, 0,0,0,0));
    for (int i = 0; i < 65540; i++) begin
      @(posedge clk);
    end
    #1;
    chk("sat_ready", 32'(issue_ready), 32'd0);
    chk("sat_stall", 32'(stall_count), 32'hFFFF);
    apply(v(1,6,1,0,0,0,0,0,0,0, 0,8'h40,16'hFFFF,1));
    apply(v(0,0,0,0,0,0,0,1,6,0, 1,8'h00,16'hFFFF,1));

    // reset clears sticky flag and stall counter
    reset = 1'b0;
    drive(v(1,0,0,0,0,3,1,0,0,0, 0,0,0,0));
    #1;
    chk("rst2_ready", 32'(issue_ready), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    chk("rst2_uf", 32'(underflow_err), 32'd0);
    chk("rst2_stall", 32'(stall_count), 32'd0);
    chk("rst2_busy", 32'(busy_mask), 32'h00);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
